// File: rtl/morse_serializer.sv
// Morse pattern serializer: shifts an encoded pattern out one bit per Morse unit, then a silent gap.
// Optional build macro MORSE_MSB_FIRST_EN sends the pattern from bit eff_len-1 down to bit 0.
module morse_serializer #(
   parameter int PATTERN_W = 13,
   parameter int LEN_W     = 4,
   parameter int UNIT_DIV  = 50000,
   parameter int GAP_UNITS = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [PATTERN_W-1:0] data_in,
   input  logic [LEN_W-1:0]     len_in,
   output logic                 ready,
   output logic                 busy,
   output logic                 morse_out,
   output logic                 done
);

   localparam int PRE_W   = (UNIT_DIV > 1) ? $clog2(UNIT_DIV) : 1;
   localparam int GAP_CYC = (GAP_UNITS > 0) ? GAP_UNITS * UNIT_DIV : 1;
   localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(UNIT_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PATTERN_W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [PATTERN_W-1:0] shift_q, shift_d;
   logic [LEN_W-1:0]     bits_q, bits_d;
   logic [PRE_W-1:0]     pre_q, pre_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic                 morse_q, morse_d;
   logic                 done_q, done_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic [LEN_W-1:0]     eff_len_s;
   logic [PATTERN_W-1:0] load_s;

   // Output bit and shift direction depend on the transmission order of the build.
   function automatic logic out_bit(input logic [PATTERN_W-1:0] v);
`ifdef MORSE_MSB_FIRST_EN
      return v[PATTERN_W-1];
`else
      return v[0];
`endif
   endfunction

   function automatic logic [PATTERN_W-1:0] shift_fn(input logic [PATTERN_W-1:0] v);
`ifdef MORSE_MSB_FIRST_EN
      return v << 1;
`else
      return v >> 1;
`endif
   endfunction

   assign eff_len_s = (len_in > LEN_MAX) ? LEN_MAX : len_in;
`ifdef MORSE_MSB_FIRST_EN
   assign load_s = data_in << (LEN_MAX - eff_len_s);
`else
   assign load_s = data_in;
`endif

   // Next-state and next-output logic for the IDLE/SHIFT/GAP sequencer.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bits_d  = bits_q;
      pre_d   = pre_q;
      gap_d   = gap_q;
      morse_d = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable && (len_in != {LEN_W{1'b0}})) begin
               state_d = ST_SHIFT;
               shift_d = load_s;
               bits_d  = eff_len_s;
               pre_d   = {PRE_W{1'b0}};
               morse_d = out_bit(load_s);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (pre_q == PRE_LAST) begin
               pre_d   = {PRE_W{1'b0}};
               shift_d = shift_fn(shift_q);
               bits_d  = bits_q - LEN_W'(1);
               if (bits_q == LEN_W'(1)) begin
                  // Last unit expired: either start the gap or finish right here.
                  gap_d = {GAP_W{1'b0}};
                  if (GAP_UNITS > 0) begin
                     state_d = ST_GAP;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  morse_d = out_bit(shift_d);
               end
            end else begin
               pre_d   = pre_q + PRE_W'(1);
               morse_d = out_bit(shift_q);
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
               gap_d   = {GAP_W{1'b0}};
               done_d  = 1'b1;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ready_d = (state_d == ST_IDLE);
      busy_d  = ~ready_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shift_q <= {PATTERN_W{1'b0}};
         bits_q  <= {LEN_W{1'b0}};
         pre_q   <= {PRE_W{1'b0}};
         gap_q   <= {GAP_W{1'b0}};
         morse_q <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bits_q  <= bits_d;
         pre_q   <= pre_d;
         gap_q   <= gap_d;
         morse_q <= morse_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign ready     = ready_q;
   assign busy      = busy_q;
   assign morse_out = morse_q;
   assign done      = done_q;

endmodule

// File: doc/morse_serializer.md
Name: morse_serializer

Overview:
- Parametrised Morse transmitter and the successor to the fixed 13-bit pattern shift register.
- Accepts a pre-encoded Morse pattern of programmable length and shifts it out one bit per Morse time unit.
- Appends an inter-character gap and reports completion.
- Sits between the character-to-pattern encoder and the LED/tone output driver; runs on the system clock instead of a strobe clock.

Parameters:
- PATTERN_W, 13, width of the encoded pattern (1 bit per Morse unit, 1 = tone on).
- LEN_W, 4, width of the length field; must satisfy 2^LEN_W > PATTERN_W.
- UNIT_DIV, 50000, clock cycles per Morse unit; must be >= 1.
- GAP_UNITS, 3, silent units appended after each pattern; 0 = no gap.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  load strobe; sampled high in IDLE starts a transfer.
- data_in  input  PATTERN_W  encoded pattern, bit 0 sent first.
- len_in  input  LEN_W  number of pattern bits to send.
- ready  output  1  high in IDLE; enable is accepted only when ready=1.
- busy  output  1  high in SHIFT or GAP (equal to ~ready).
- morse_out  output  1  serial Morse output, registered.
- done  output  1  one-cycle pulse when the gap completes.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, shift register=0, bit counter=0, prescaler=0, morse_out=0, done=0, ready=1, busy=0.
- FSM has three states: IDLE, SHIFT and GAP.
- IDLE:
  - morse_out=0.
  - On a clk edge with enable=1 and len_in!=0: latch data_in into the shift register and eff_len=min(len_in, PATTERN_W) into the bit counter; go to SHIFT.
  - enable=1 with len_in=0: ignored; stay IDLE; no done pulse.
- SHIFT:
  - morse_out=shift_reg[0] starting the cycle after acceptance (latency 1).
  - Each bit is held exactly UNIT_DIV cycles. The prescaler counts 0..UNIT_DIV-1; at terminal count:
    - shift right with zero fill;
    - decrement the bit counter;
    - clear the prescaler.
  - When the last bit's unit expires: go to GAP if GAP_UNITS>0; otherwise pulse done and go to IDLE.
- GAP:
  - morse_out=0 for GAP_UNITS*UNIT_DIV cycles.
  - Then done=1 for one cycle and go to IDLE, where ready=1 in that same cycle.
- Total busy time = (eff_len+GAP_UNITS)*UNIT_DIV cycles.
- enable while busy: ignored; the data in flight is unaffected and there is no queueing.
- Back-to-back: enable held high continuously starts the next transfer in the cycle ready returns high. There is no idle gap beyond GAP.
- Bits of data_in above eff_len are never output.
- Reset asserted mid-transfer: outputs drop to reset values immediately; no done pulse.
- Counters:
  - prescaler width = clog2(UNIT_DIV), minimum 1;
  - gap counter sized for GAP_UNITS*UNIT_DIV;
  - no wrap beyond terminal counts.

Optional Feature:
- Macro: MORSE_MSB_FIRST_EN.
- Defined:
  - the pattern is sent starting at bit eff_len-1 down to bit 0;
  - the loaded value is left-aligned, so morse_out=shift_reg[PATTERN_W-1];
  - shifts are left with zero fill.
- Undefined: LSB-first as above.
- Timing, length, gap and handshake behaviour are identical in both builds.

Test Plan:
- Reset mid-transfer: UNIT_DIV=2, GAP_UNITS=3; load data_in=13'b0_0000_0001_0111, len_in=5; assert rst_n=0 during the 3rd bit.
  - Required: morse_out=0, busy=0, ready=1 immediately; no done pulse.
  - Repeat the same load without reset: morse_out=1,1,1,0,1 with each bit held 2 cycles, then 6 cycles of 0, then done for 1 cycle; busy high 16 cycles total.
- len_in=0 with enable=1: ready stays 1, busy stays 0, morse_out=0, no done.
- Over-length: len_in=15 with PATTERN_W=13, data_in=all ones.
  - Required: exactly 13 units of 1, then the gap; busy = (13+3)*UNIT_DIV cycles.
- Enable pulsed while busy with a different data_in: the output stream matches the first pattern only.
  - Enable held high continuously: the second transfer's first bit appears 1 cycle after done.
- GAP_UNITS=0, UNIT_DIV=1, len_in=3, data_in=3'b101: morse_out=1,0,1 on consecutive cycles; done is asserted in the cycle after the last bit.
- MORSE_MSB_FIRST_EN defined, data_in=5'b10110, len_in=5: morse_out=1,0,1,1,0.
